pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers that replaces the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB register modules in the SPARC datapath.
- Each stage carries a data field, a control-signal field and a valid bit.
- Supports per-stage hold (stall) and per-stage flush. Bubbles are inserted automatically below a held stage.
- Provides occupancy and stall-cycle statistics for the hazard unit and the bench.

Parameters:
DATA_W, 32, width of the data field per stage (PC, operands, immediates).
CTRL_W, 16, width of the control-signal field per stage. Zeroed on a bubble, so the bubble is a NOP.
STAGES, 4, number of register stages; must be >= 1.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
R  input  1  reset, asynchronous, active-low.
LE  input  1  global load enable; 0 freezes all state.
hold  input  STAGES  per-stage stall; bit k holds stage k.
flush  input  STAGES  per-stage flush; bit k squashes stage k.
D_in  input  DATA_W  data into stage 0.
C_in  input  CTRL_W  control into stage 0.
V_in  input  1  valid into stage 0.
Q_data  output  DATA_W  data of stage STAGES-1.
Q_ctrl  output  CTRL_W  control of stage STAGES-1.
Q_valid  output  1  valid of stage STAGES-1.
tap_data  output  STAGES*DATA_W  all stage data; stage k at [k*DATA_W +: DATA_W].
tap_ctrl  output  STAGES*CTRL_W  all stage control; stage k at [k*CTRL_W +: CTRL_W].
tap_valid  output  STAGES  valid bit of each stage.
occupancy  output  $clog2(STAGES+1)  number of stages with valid=1; combinational.
stall_cnt  output  CNT_W  number of cycles in which any hold bit was sampled high.

Behaviour:
- Reset:
  - R low asynchronously clears every stage: data=0, ctrl=0, valid=0.
  - stall_cnt=0; consequently occupancy=0 and all outputs are 0 while R is low.
  - Deassertion takes effect at the first rising edge with R high. Reset mid-operation discards all in-flight contents.
- LE=0: no stage and no counter changes at the edge. hold and flush are ignored that cycle.
- With LE=1, each stage k updates at the rising edge by first-match priority:
  1. flush[k]=1 -> bubble (data=0, ctrl=0, valid=0).
  2. hold[k]=1 -> retain current contents.
  3. k>0 and hold[k-1]=1 -> bubble. The upstream stage keeps its contents, so nothing is duplicated.
  4. Otherwise load upstream: stage 0 takes {D_in, C_in, V_in}; stage k takes stage k-1.
- Flush has priority over hold on the same stage.
- Simultaneous flush[k] and hold[k-1]: bubble, which is consistent with rule 3.
- Flushing an upstream stage does not affect the content arriving at stage k in the same cycle. Stage k takes the pre-edge value of stage k-1.
- Invalid entries (valid=0) propagate like any other content. Their data and ctrl are passed through unchanged; only bubbles force zero.
- Latency: with hold=0, flush=0 and LE=1, a value sampled at stage 0 on edge n appears on Q_* after edge n+STAGES-1, i.e. STAGES edges from input to output.
- STAGES=1: rule 3 never applies; Q_* equals stage 0.
- stall_cnt:
  - Increments by 1 on each edge with LE=1 and |hold=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- occupancy is the popcount of tap_valid, range 0..STAGES.
- No combinational path from any input to Q_*, tap_* or stall_cnt. occupancy depends only on registered valids.

Test Plan:
1. Reset and fill: R low at t=0, released at t=3. Then LE=1 and stream D_in=1,2,3,4,5 with V_in=1, STAGES=4. Required: all outputs are 0 during reset; Q_data=1 with Q_valid=1 after the 4th edge post-reset; occupancy=4; then Q_data=2,3,… on consecutive edges.
2. Load-use stall: pipe full with 10,11,12,13 (stage 3..0). Assert hold=4'b0011 for 1 cycle. Required after the edge:
   - stage0=13 and stage1=12 are retained.
   - stage2 is a bubble (valid=0, ctrl=0, data=0).
   - stage3=11.
   - stall_cnt=1 and occupancy=3.
3. Branch flush: pipe full. Assert flush=4'b0011 and hold=0 for one edge. Required:
   - stages 0 and 1 become bubbles.
   - stage2 receives the pre-edge stage1 value, stage3 the pre-edge stage2 value.
   - occupancy=2.
4. Flush vs hold priority: flush[2]=1 and hold[2]=1 on the same edge. Required: stage2 becomes a bubble; stall_cnt still increments.
5. Global freeze: LE=0 for 3 edges with hold=4'b1111, flush=4'b1111 and a changing D_in. Required: all taps unchanged and stall_cnt unchanged. Then R pulsed low mid-freeze -> all taps immediately 0.
6. Saturation: CNT_W=3 with hold[0]=1 for 10 edges. Required: stall_cnt reads 1..7 then stays 7.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers (data, control, valid per stage)
// with per-stage hold and flush, automatic bubble insertion below a held
// stage, a popcount of valid stages and a saturating stall-cycle counter.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                          Clk,
  input  logic                          R,
  input  logic                          LE,
  input  logic [STAGES-1:0]             hold,
  input  logic [STAGES-1:0]             flush,
  input  logic [DATA_W-1:0]             D_in,
  input  logic [CTRL_W-1:0]             C_in,
  input  logic                          V_in,
  output logic [DATA_W-1:0]             Q_data,
  output logic [CTRL_W-1:0]             Q_ctrl,
  output logic                          Q_valid,
  output logic [STAGES*DATA_W-1:0]      tap_data,
  output logic [STAGES*CTRL_W-1:0]      tap_ctrl,
  output logic [STAGES-1:0]             tap_valid,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [OCC_W-1:0]              occ_sum;

  // Next-state of every stage: flush beats hold, a stage below a held one
  // takes a bubble so the retained upstream entry is never duplicated.
  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (LE) begin
      if (flush[0]) begin
        data_d[0]  = '0;
        ctrl_d[0]  = '0;
        valid_d[0] = 1'b0;
      end else if (!hold[0]) begin
        data_d[0]  = D_in;
        ctrl_d[0]  = C_in;
        valid_d[0] = V_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (flush[k] || (!hold[k] && hold[k-1])) begin
          data_d[k]  = '0;
          ctrl_d[k]  = '0;
          valid_d[k] = 1'b0;
        end else if (!hold[k]) begin
          data_d[k]  = data_q[k-1];
          ctrl_d[k]  = ctrl_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
  end

  // Stall counter counts enabled cycles with any hold bit set and sticks at
  // its maximum instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (LE && (|hold) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stage registers; reset discards all in-flight contents.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  // Stall statistics register, cleared only by reset.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Occupancy is a popcount of the registered valid bits only.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_sum = occ_sum + OCC_W'(valid_q[k]);
    end
  end

  assign occupancy = occ_sum;
  assign stall_cnt = stall_cnt_q;
  assign tap_data  = data_q;
  assign tap_ctrl  = ctrl_q;
  assign tap_valid = valid_q;
  assign Q_data    = data_q[STAGES-1];
  assign Q_ctrl    = ctrl_q[STAGES-1];
  assign Q_valid   = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus a random
// phase, all checked against a stage-array reference model.
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NS = 4;
  localparam int CNT_BIG = 16;
  localparam int CNT_SMALL = 3;

  logic          clk = 1'b0;
  logic          r_n = 1'b1;
  logic          le;
  logic [NS-1:0] hold;
  logic [NS-1:0] flush;
  logic [DW-1:0] d_in;
  logic [CW-1:0] c_in;
  logic          v_in;

  logic [DW-1:0]    q_data;
  logic [CW-1:0]    q_ctrl;
  logic             q_valid;
  logic [NS*DW-1:0] tap_data;
  logic [NS*CW-1:0] tap_ctrl;
  logic [NS-1:0]    tap_valid;
  logic [2:0]       occupancy;
  logic [CNT_BIG-1:0] stall_cnt;

  logic [DW-1:0]    s_q_data;
  logic [CW-1:0]    s_q_ctrl;
  logic             s_q_valid;
  logic [NS*DW-1:0] s_tap_data;
  logic [NS*CW-1:0] s_tap_ctrl;
  logic [NS-1:0]    s_tap_valid;
  logic [2:0]       s_occupancy;
  logic [CNT_SMALL-1:0] s_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_data [NS];
  logic [CW-1:0] m_ctrl [NS];
  logic          m_valid[NS];
  int            m_stalls;

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(NS), .CNT_W(CNT_BIG)) dut (
    .Clk(clk), .R(r_n), .LE(le), .hold(hold), .flush(flush),
    .D_in(d_in), .C_in(c_in), .V_in(v_in),
    .Q_data(q_data), .Q_ctrl(q_ctrl), .Q_valid(q_valid),
    .tap_data(tap_data), .tap_ctrl(tap_ctrl), .tap_valid(tap_valid),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(NS), .CNT_W(CNT_SMALL)) dut_small (
    .Clk(clk), .R(r_n), .LE(le), .hold(hold), .flush(flush),
    .D_in(d_in), .C_in(c_in), .V_in(v_in),
    .Q_data(s_q_data), .Q_ctrl(s_q_ctrl), .Q_valid(s_q_valid),
    .tap_data(s_tap_data), .tap_ctrl(s_tap_ctrl), .tap_valid(s_tap_valid),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int satCount(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NS; k++) begin
      m_data[k]  = '0;
      m_ctrl[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_stalls = 0;
  endtask

  // Apply the per-stage priority rules to a snapshot of the pre-edge state.
  task automatic modelEdge();
    logic [DW-1:0] pd[NS];
    logic [CW-1:0] pc[NS];
    logic          pv[NS];
    for (int k = 0; k < NS; k++) begin
      pd[k] = m_data[k];
      pc[k] = m_ctrl[k];
      pv[k] = m_valid[k];
    end
    if (!le) return;
    if (hold != '0) m_stalls++;
    for (int k = 0; k < NS; k++) begin
      if (flush[k]) begin
        m_data[k] = '0; m_ctrl[k] = '0; m_valid[k] = 1'b0;
      end else if (hold[k]) begin
        m_data[k] = pd[k]; m_ctrl[k] = pc[k]; m_valid[k] = pv[k];
      end else if (k > 0 && hold[k-1]) begin
        m_data[k] = '0; m_ctrl[k] = '0; m_valid[k] = 1'b0;
      end else if (k == 0) begin
        m_data[k] = d_in; m_ctrl[k] = c_in; m_valid[k] = v_in;
      end else begin
        m_data[k] = pd[k-1]; m_ctrl[k] = pc[k-1]; m_valid[k] = pv[k-1];
      end
    end
  endtask

  task automatic compareValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int occ;
    occ = 0;
    for (int k = 0; k < NS; k++) begin
      compareValue($sformatf("stage%0d data", k), 64'(tap_data[k*DW +: DW]), 64'(m_data[k]));
      compareValue($sformatf("stage%0d ctrl", k), 64'(tap_ctrl[k*CW +: CW]), 64'(m_ctrl[k]));
      compareValue($sformatf("stage%0d valid", k), 64'(tap_valid[k]), 64'(m_valid[k]));
      if (m_valid[k]) occ++;
    end
    compareValue("Q_data", 64'(q_data), 64'(m_data[NS-1]));
    compareValue("Q_ctrl", 64'(q_ctrl), 64'(m_ctrl[NS-1]));
    compareValue("Q_valid", 64'(q_valid), 64'(m_valid[NS-1]));
    compareValue("occupancy", 64'(occupancy), 64'(occ));
    compareValue("stall_cnt", 64'(stall_cnt), 64'(satCount(m_stalls, CNT_BIG)));
    compareValue("small stall_cnt", 64'(s_stall_cnt), 64'(satCount(m_stalls, CNT_SMALL)));
    compareValue("small Q_data", 64'(s_q_data), 64'(m_data[NS-1]));
  endtask

  task automatic applyStimulus(input logic le_i, input logic [NS-1:0] hold_i,
                               input logic [NS-1:0] flush_i, input logic [DW-1:0] d_i,
                               input logic [CW-1:0] c_i, input logic v_i);
    le    = le_i;
    hold  = hold_i;
    flush = flush_i;
    d_in  = d_i;
    c_in  = c_i;
    v_in  = v_i;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    r_n = 1'b0;
    le = 1'b0; hold = '0; flush = '0; d_in = '0; c_in = '0; v_in = 1'b0;
    modelReset();
    #1;
    $display("[TB] reset and fill");
    checkOutput();
    #2 r_n = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, '0, '0, DW'(i), CW'($urandom), 1'b1);
      checkOutput();
      if (i == 4) begin
        compareValue("fill Q_data", 64'(q_data), 64'd1);
        compareValue("fill Q_valid", 64'(q_valid), 64'd1);
        compareValue("fill occupancy", 64'(occupancy), 64'd4);
      end
      if (i == 5) compareValue("fill next Q_data", 64'(q_data), 64'd2);
    end

    $display("[TB] load-use stall");
    for (int i = 10; i <= 13; i++) begin
      applyStimulus(1'b1, '0, '0, DW'(i), CW'($urandom), 1'b1);
      checkOutput();
    end
    applyStimulus(1'b1, 4'b0011, '0, 32'd99, CW'($urandom), 1'b1);
    checkOutput();
    compareValue("stall stage0", 64'(tap_data[0 +: DW]), 64'd13);
    compareValue("stall stage1", 64'(tap_data[DW +: DW]), 64'd12);
    compareValue("stall stage2 valid", 64'(tap_valid[2]), 64'd0);
    compareValue("stall stage2 data", 64'(tap_data[2*DW +: DW]), 64'd0);
    compareValue("stall stage2 ctrl", 64'(tap_ctrl[2*CW +: CW]), 64'd0);
    compareValue("stall stage3", 64'(tap_data[3*DW +: DW]), 64'd11);
    compareValue("stall count", 64'(stall_cnt), 64'd1);
    compareValue("stall occupancy", 64'(occupancy), 64'd3);

    $display("[TB] branch flush");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, '0, '0, $urandom, CW'($urandom), 1'b1);
      checkOutput();
    end
    applyStimulus(1'b1, '0, 4'b0011, $urandom, CW'($urandom), 1'b1);
    checkOutput();
    compareValue("flush occupancy", 64'(occupancy), 64'd2);
    compareValue("flush stage0 valid", 64'(tap_valid[0]), 64'd0);

    $display("[TB] flush vs hold priority");
    applyStimulus(1'b1, 4'b0100, 4'b0100, $urandom, CW'($urandom), 1'b1);
    checkOutput();
    compareValue("prio stage2 valid", 64'(tap_valid[2]), 64'd0);
    compareValue("prio stall count", 64'(stall_cnt), 64'd2);

    $display("[TB] global freeze");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, 4'hF, $urandom, CW'($urandom), 1'b1);
      checkOutput();
    end
    compareValue("freeze stall count", 64'(stall_cnt), 64'd2);
    #2 r_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    compareValue("freeze reset Q_valid", 64'(q_valid), 64'd0);
    compareValue("freeze reset taps", 64'(tap_data), 64'd0);
    #1 r_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom % 8) != 0,
                    (($urandom % 4) == 0) ? NS'($urandom) : '0,
                    (($urandom % 5) == 0) ? NS'($urandom) : '0,
                    $urandom, CW'($urandom), 1'($urandom));
      checkOutput();
    end

    $display("[TB] stall counter saturation");
    r_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    #2 r_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 4'b0001, '0, $urandom, CW'($urandom), 1'b1);
      checkOutput();
      compareValue("saturating count", 64'(s_stall_cnt), 64'((i < 7) ? i : 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
